// File: rtl/montprod_opmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : montprod_opmem_pkg
// Description : Shared widths, bank selects and FSM encoding for the montprod
//               operand/result memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
package montprod_opmem_pkg;

    localparam int OPMEM_ADDR_WIDTH  = 8;
    localparam int OPMEM_DATA_WIDTH  = 32;
    localparam int OPMEM_COUNT_WIDTH = 8;

    // Host bank selects
    localparam logic [1:0] BANK_A = 2'd0;
    localparam logic [1:0] BANK_B = 2'd1;
    localparam logic [1:0] BANK_M = 2'd2;
    localparam logic [1:0] BANK_R = 2'd3;

    // Calculation sequencer states (ST_COPY only reachable with copy-back)
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PULSE     = 3'd1,
        ST_WAIT_ACK  = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_COPY      = 3'd4,
        ST_DONE      = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/montprod_opmem_if.sv
`default_nettype none
// ============================================================================
// Module      : montprod_opmem_if
// Description : Host bus plus montprod operand/result bus of the opmem block.
//               slave = the memory responder, master = host + montprod side.
// Revision    : 1.0 - initial release
// ============================================================================
interface montprod_opmem_if
    import montprod_opmem_pkg::*;
#(
    parameter int ADDR_WIDTH = OPMEM_ADDR_WIDTH,
    parameter int DATA_WIDTH = OPMEM_DATA_WIDTH
) ();

    // Host register access
    logic                         host_cs;
    logic                         host_we;
    logic [1:0]                   host_bank;
    logic [ADDR_WIDTH-1:0]        host_addr;
    logic [DATA_WIDTH-1:0]        host_wdata;
    logic [DATA_WIDTH-1:0]        host_rdata;

    // Host calculation control
    logic                         start;
    logic [ADDR_WIDTH-1:0]        length;
    logic                         busy;
    logic                         done;
    logic [OPMEM_COUNT_WIDTH-1:0] res_count;

    // montprod core side
    logic                         mp_calculate;
    logic                         mp_ready;
    logic [ADDR_WIDTH-1:0]        mp_length;
    logic [ADDR_WIDTH-1:0]        opa_addr;
    logic [ADDR_WIDTH-1:0]        opb_addr;
    logic [ADDR_WIDTH-1:0]        opm_addr;
    logic [DATA_WIDTH-1:0]        opa_data;
    logic [DATA_WIDTH-1:0]        opb_data;
    logic [DATA_WIDTH-1:0]        opm_data;
    logic [ADDR_WIDTH-1:0]        result_addr;
    logic [DATA_WIDTH-1:0]        result_data;
    logic                         result_we;

    modport slave (
        input  host_cs, host_we, host_bank, host_addr, host_wdata,
        input  start, length, mp_ready,
        input  opa_addr, opb_addr, opm_addr,
        input  result_addr, result_data, result_we,
        output host_rdata, busy, done, res_count,
        output mp_calculate, mp_length,
        output opa_data, opb_data, opm_data
    );

    modport master (
        output host_cs, host_we, host_bank, host_addr, host_wdata,
        output start, length, mp_ready,
        output opa_addr, opb_addr, opm_addr,
        output result_addr, result_data, result_we,
        input  host_rdata, busy, done, res_count,
        input  mp_calculate, mp_length,
        input  opa_data, opb_data, opm_data
    );

endinterface
`default_nettype wire

// File: rtl/montprod_opmem_bank.sv
`default_nettype none
// ============================================================================
// Module      : montprod_opmem_bank
// Description : One operand/result word bank: single write port and two
//               registered read ports (host, montprod). Reads return the
//               word stored before a same-cycle write.
// Revision    : 1.0 - initial release
// ============================================================================
module montprod_opmem_bank
    import montprod_opmem_pkg::*;
#(
    parameter int ADDR_WIDTH = OPMEM_ADDR_WIDTH,
    parameter int DATA_WIDTH = OPMEM_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  hre_i,
    input  logic [ADDR_WIDTH-1:0] haddr_i,
    output logic [DATA_WIDTH-1:0] hrdata_o,
    input  logic [ADDR_WIDTH-1:0] maddr_i,
    output logic [DATA_WIDTH-1:0] mrdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [0:(1<<ADDR_WIDTH)-1];
    logic [DATA_WIDTH-1:0] hrdata_q;
    logic [DATA_WIDTH-1:0] mrdata_q;

    // Storage array write; contents survive reset
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Registered read ports; montprod port reads every cycle, host on request
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hrdata_q <= '0;
            mrdata_q <= '0;
        end else begin
            mrdata_q <= mem_q[maddr_i];
            if (hre_i) begin
                hrdata_q <= mem_q[haddr_i];
            end
        end
    end

    assign hrdata_o = hrdata_q;
    assign mrdata_o = mrdata_q;

endmodule
`default_nettype wire

// File: rtl/montprod_opmem.sv
`default_nettype none
// ============================================================================
// Module      : montprod_opmem
// Description : Memory-side responder for montprod. Holds banks A, B, M, R,
//               serves montprod reads with one-cycle latency, captures result
//               writes and sequences a calculation for the host.
//               Optional feature macro: MONTPROD_OPMEM_COPYBACK_EN
//               (copy R[0..length-1] back into A after each run).
// Revision    : 1.0 - initial release
// ============================================================================
module montprod_opmem
    import montprod_opmem_pkg::*;
#(
    parameter int ADDR_WIDTH = OPMEM_ADDR_WIDTH,
    parameter int DATA_WIDTH = OPMEM_DATA_WIDTH
) (
    input  logic           clk,
    input  logic           reset,
    montprod_opmem_if.slave bus
);

    state_t                       state_q, state_d;
    logic [ADDR_WIDTH-1:0]        len_q, len_d;
    logic [OPMEM_COUNT_WIDTH-1:0] res_count_q, res_count_d;
    logic [1:0]                   rd_bank_q;

    logic                         w_busy, w_done, w_calc, w_res_accept;
    logic                         w_host_wr, w_host_rd;

    logic [DATA_WIDTH-1:0]        w_a_hdata, w_b_hdata, w_m_hdata, w_r_hdata;
    logic [DATA_WIDTH-1:0]        w_a_mdata, w_b_mdata, w_m_mdata;
    logic [DATA_WIDTH-1:0]        w_host_rdata;

    logic                         w_a_we, w_r_we;
    logic [ADDR_WIDTH-1:0]        w_a_waddr, w_r_waddr, w_r_maddr;
    logic [DATA_WIDTH-1:0]        w_a_wdata, w_r_wdata;

`ifdef MONTPROD_OPMEM_COPYBACK_EN
    // Copy pipeline: R is read at copy_idx, the word lands in A one cycle later
    logic [ADDR_WIDTH-1:0]        copy_idx_q, copy_idx_d;
    logic [ADDR_WIDTH-1:0]        copy_waddr_q, copy_waddr_d;
    logic                         copy_wvalid_q, copy_wvalid_d;
    logic [DATA_WIDTH-1:0]        w_r_mdata;
`else
    logic [DATA_WIDTH-1:0]        w_unused_r_mdata;
`endif

    // Host strobes; all bank writes from the host are blocked while busy
    assign w_host_wr = bus.host_cs & bus.host_we & ~w_busy;
    assign w_host_rd = bus.host_cs & ~bus.host_we;

    // Sequencer next state and Moore outputs
    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        res_count_d  = res_count_q;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        w_calc       = 1'b0;
        w_res_accept = 1'b0;
`ifdef MONTPROD_OPMEM_COPYBACK_EN
        copy_idx_d    = '0;
        copy_wvalid_d = 1'b0;
        copy_waddr_d  = copy_waddr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    len_d       = bus.length;
                    res_count_d = '0;
                    state_d     = (bus.length == '0) ? ST_DONE : ST_PULSE;
                end
            end
            ST_PULSE: begin
                w_busy  = 1'b1;
                w_calc  = 1'b1;
                state_d = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                w_busy       = 1'b1;
                w_res_accept = bus.result_we;
                if (!bus.mp_ready) begin
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                w_busy       = 1'b1;
                w_res_accept = bus.result_we;
                if (bus.mp_ready) begin
`ifdef MONTPROD_OPMEM_COPYBACK_EN
                    state_d = ST_COPY;
`else
                    state_d = ST_DONE;
`endif
                end
            end
            ST_COPY: begin
                w_busy = 1'b1;
`ifdef MONTPROD_OPMEM_COPYBACK_EN
                // Final pending write commits on the same edge we leave
                if (copy_idx_q != len_q) begin
                    copy_idx_d    = copy_idx_q + ADDR_WIDTH'(1);
                    copy_wvalid_d = 1'b1;
                    copy_waddr_d  = copy_idx_q;
                end else begin
                    state_d = ST_DONE;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            ST_DONE: begin
                w_done  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (w_res_accept && (res_count_q != {OPMEM_COUNT_WIDTH{1'b1}})) begin
            res_count_d = res_count_q + OPMEM_COUNT_WIDTH'(1);
        end
    end

    // Sequencer and control registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            res_count_q <= '0;
            rd_bank_q   <= BANK_A;
`ifdef MONTPROD_OPMEM_COPYBACK_EN
            copy_idx_q    <= '0;
            copy_waddr_q  <= '0;
            copy_wvalid_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            res_count_q <= res_count_d;
            if (w_host_rd) begin
                rd_bank_q <= bus.host_bank;
            end
`ifdef MONTPROD_OPMEM_COPYBACK_EN
            copy_idx_q    <= copy_idx_d;
            copy_waddr_q  <= copy_waddr_d;
            copy_wvalid_q <= copy_wvalid_d;
`endif
        end
    end

    // Write-port steering for banks A and R (host vs copy / result capture)
    always_comb begin
        w_a_we    = w_host_wr && (bus.host_bank == BANK_A);
        w_a_waddr = bus.host_addr;
        w_a_wdata = bus.host_wdata;
        w_r_we    = w_host_wr && (bus.host_bank == BANK_R);
        w_r_waddr = bus.host_addr;
        w_r_wdata = bus.host_wdata;
`ifdef MONTPROD_OPMEM_COPYBACK_EN
        if (copy_wvalid_q) begin
            w_a_we    = 1'b1;
            w_a_waddr = copy_waddr_q;
            w_a_wdata = w_r_mdata;
        end
`endif
        if (w_res_accept) begin
            w_r_we    = 1'b1;
            w_r_waddr = bus.result_addr;
            w_r_wdata = bus.result_data;
        end
    end

`ifdef MONTPROD_OPMEM_COPYBACK_EN
    assign w_r_maddr = copy_idx_q;
`else
    assign w_r_maddr = '0;
`endif

    // Host read-data select, using the bank captured with the read request
    always_comb begin
        case (rd_bank_q)
            BANK_A:  w_host_rdata = w_a_hdata;
            BANK_B:  w_host_rdata = w_b_hdata;
            BANK_M:  w_host_rdata = w_m_hdata;
            default: w_host_rdata = w_r_hdata;
        endcase
    end

    montprod_opmem_bank #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_bank_a (
        .clk(clk), .reset(reset),
        .we_i(w_a_we), .waddr_i(w_a_waddr), .wdata_i(w_a_wdata),
        .hre_i(w_host_rd), .haddr_i(bus.host_addr), .hrdata_o(w_a_hdata),
        .maddr_i(bus.opa_addr), .mrdata_o(w_a_mdata)
    );

    montprod_opmem_bank #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_bank_b (
        .clk(clk), .reset(reset),
        .we_i(w_host_wr && (bus.host_bank == BANK_B)), .waddr_i(bus.host_addr), .wdata_i(bus.host_wdata),
        .hre_i(w_host_rd), .haddr_i(bus.host_addr), .hrdata_o(w_b_hdata),
        .maddr_i(bus.opb_addr), .mrdata_o(w_b_mdata)
    );

    montprod_opmem_bank #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_bank_m (
        .clk(clk), .reset(reset),
        .we_i(w_host_wr && (bus.host_bank == BANK_M)), .waddr_i(bus.host_addr), .wdata_i(bus.host_wdata),
        .hre_i(w_host_rd), .haddr_i(bus.host_addr), .hrdata_o(w_m_hdata),
        .maddr_i(bus.opm_addr), .mrdata_o(w_m_mdata)
    );

    montprod_opmem_bank #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_bank_r (
        .clk(clk), .reset(reset),
        .we_i(w_r_we), .waddr_i(w_r_waddr), .wdata_i(w_r_wdata),
        .hre_i(w_host_rd), .haddr_i(bus.host_addr), .hrdata_o(w_r_hdata),
        .maddr_i(w_r_maddr),
`ifdef MONTPROD_OPMEM_COPYBACK_EN
        .mrdata_o(w_r_mdata)
`else
        .mrdata_o(w_unused_r_mdata)
`endif
    );

    assign bus.host_rdata   = w_host_rdata;
    assign bus.busy         = w_busy;
    assign bus.done         = w_done;
    assign bus.res_count    = res_count_q;
    assign bus.mp_calculate = w_calc;
    assign bus.mp_length    = len_q;
    assign bus.opa_data     = w_a_mdata;
    assign bus.opb_data     = w_b_mdata;
    assign bus.opm_data     = w_m_mdata;

endmodule
`default_nettype wire
